// File: rtl/i2s_led_pkg.sv
// i2s_led_pkg: shared constants, state encoding and header packing for the LED
// panel stream sequencer.
//   HDR_BITS / WORD_BITS : bit lengths of the row header and of a payload word
//   NX / NY / ROW        : bit offsets of the header fields
//   MAX_ROW_BITS         : largest payload per row the downstream 12-bit bit
//                          counter can address
//   seq_state_e          : sequencer FSM states
//   make_header()        : packs {nx, ny, 2'b00, row} into a 16-bit header
package i2s_led_pkg;

    localparam int unsigned HDR_BITS     = 16;
    localparam int unsigned WORD_BITS    = 16;
    localparam int unsigned NX           = 12;
    localparam int unsigned NY           = 8;
    localparam int unsigned ROW          = 0;
    localparam int unsigned MAX_ROW_BITS = 4095;

    typedef enum logic [2:0] {IDLE, HDR, DATA, PAD, DONE} seq_state_e;

    function automatic logic [HDR_BITS-1:0] make_header(input logic [3:0] nx,
                                                        input logic [3:0] ny,
                                                        input logic [5:0] row);
        logic [HDR_BITS-1:0] h;
        h           = '0;
        h[NX +: 4]  = nx;
        h[NY +: 4]  = ny;
        h[ROW +: 6] = row;
        return h;
    endfunction

endpackage

// File: rtl/i2s_word_serializer.sv
// i2s_word_serializer: prefetch register plus 16-bit MSB-first shifter.
// Ports:
//   i2s_clk, rst_n : bit clock, synchronous active-low reset
//   rd             : frame-memory read strobe; rdata is valid the cycle after
//   rdata          : frame-memory read data
//   load           : load the shifter this edge (otherwise shift left, zero fill)
//   load_word      : on load, take the fetched memory word instead of load_val
//   load_val       : literal load value (header, or zero for pad/idle)
//   dout           : registered serial output (shifter MSB)
module i2s_word_serializer
    import i2s_led_pkg::*;
(
    input  logic                 i2s_clk,
    input  logic                 rst_n,
    input  logic                 rd,
    input  logic [WORD_BITS-1:0] rdata,
    input  logic                 load,
    input  logic                 load_word,
    input  logic [WORD_BITS-1:0] load_val,
    output logic                 dout
);

    logic                 cap_q;
    logic [WORD_BITS-1:0] pre_q;
    logic [WORD_BITS-1:0] sh_q;
    logic [WORD_BITS-1:0] fetched;

    // The word boundary can coincide with the capture cycle, so bypass the
    // prefetch register when the read data is arriving right now.
    assign fetched = cap_q ? rdata : pre_q;

    always_ff @(posedge i2s_clk) begin
        if (!rst_n) begin
            cap_q <= 1'b0;
            pre_q <= '0;
            sh_q  <= '0;
        end else begin
            cap_q <= rd;
            if (cap_q) begin
                pre_q <= rdata;
            end
            if (load) begin
                sh_q <= load_word ? fetched : load_val;
            end else begin
                sh_q <= {sh_q[WORD_BITS-2:0], 1'b0};
            end
        end
    end

    assign dout = sh_q[WORD_BITS-1];

endmodule

// File: rtl/i2s_frame_sequencer.sv
// i2s_frame_sequencer: streams a frame row by row as header, payload words
// fetched from frame memory, then one latch pad bit, gapless on i2s_data.
// Optional feature macro: I2S_SEQ_AUTOLOOP_EN adds input 'loop'; when high in
// DONE the frame restarts at row 0 with the retained configuration.
// Ports:
//   i2s_clk, rst_n      : bit clock, synchronous active-low reset
//   start               : begin a frame (accepted in IDLE only)
//   cfg_nx/ny/rows      : modules across-1, modules down-1, rows per frame-1
//   loop                : (I2S_SEQ_AUTOLOOP_EN only) re-run the frame
//   busy                : frame in progress
//   frame_done          : pulse in the cycle after the last pad bit
//   cfg_err             : pulse when start is rejected (row too long)
//   row_cur             : row currently streaming
//   mem_rd/addr/rdata   : frame-memory read port, data one cycle after mem_rd
//   i2s_data            : registered serial stream, MSB first
module i2s_frame_sequencer #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              i2s_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        cfg_nx,
    input  logic [3:0]        cfg_ny,
    input  logic [5:0]        cfg_rows,
`ifdef I2S_SEQ_AUTOLOOP_EN
    input  logic              loop,
`endif
    output logic              busy,
    output logic              frame_done,
    output logic              cfg_err,
    output logic [5:0]        row_cur,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic              i2s_data
);

    import i2s_led_pkg::*;

    localparam logic [3:0] HDR_PREFETCH  = 4'(HDR_BITS - 2);
    localparam logic [3:0] HDR_LAST      = 4'(HDR_BITS - 1);
    localparam logic [3:0] WORD_PREFETCH = 4'(WORD_BITS - 2);
    localparam logic [3:0] WORD_LAST     = 4'(WORD_BITS - 1);

    seq_state_e        state_q, state_d;
    logic [3:0]        bit_q, bit_d;
    logic [7:0]        word_q, word_d;
    logic [5:0]        row_q, row_d;
    logic [5:0]        rows_q, rows_d;
    logic [3:0]        nx_q, nx_d;
    logic [3:0]        ny_q, ny_d;
    logic [7:0]        w_q, w_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              cfg_err_q, cfg_err_d;

    logic [9:0]        w_full;
    logic [13:0]       t_full;
    logic              cfg_ok;
    logic              last_word;
    logic [8:0]        rd_off;
    logic              ser_load;
    logic              ser_word;
    logic [15:0]       ser_val;

    // Row geometry from the live config; only used at start acceptance.
    assign w_full    = ({6'd0, cfg_nx} + 10'd1) * ({6'd0, cfg_ny} + 10'd1);
    assign t_full    = {w_full, 4'b0000};
    assign cfg_ok    = (t_full <= 14'(MAX_ROW_BITS));
    assign last_word = (word_q == w_q - 8'd1);

    // base_q is the accumulated row base (+W per row), so no multiplier here.
    assign mem_addr  = base_q + ADDR_W'(rd_off);
    assign row_cur   = row_q;
    assign cfg_err   = cfg_err_q;

    always_ff @(posedge i2s_clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_q     <= '0;
            word_q    <= '0;
            row_q     <= '0;
            rows_q    <= '0;
            nx_q      <= '0;
            ny_q      <= '0;
            w_q       <= '0;
            base_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            word_q    <= word_d;
            row_q     <= row_d;
            rows_q    <= rows_d;
            nx_q      <= nx_d;
            ny_q      <= ny_d;
            w_q       <= w_d;
            base_q    <= base_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        word_d     = word_q;
        row_d      = row_q;
        rows_d     = rows_q;
        nx_d       = nx_q;
        ny_d       = ny_q;
        w_d        = w_q;
        base_d     = base_q;
        cfg_err_d  = 1'b0;
        ser_load   = 1'b0;
        ser_word   = 1'b0;
        ser_val    = '0;
        mem_rd     = 1'b0;
        rd_off     = '0;
        busy       = 1'b0;
        frame_done = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        state_d  = HDR;
                        bit_d    = '0;
                        row_d    = '0;
                        base_d   = '0;
                        nx_d     = cfg_nx;
                        ny_d     = cfg_ny;
                        rows_d   = cfg_rows;
                        w_d      = w_full[7:0];
                        ser_load = 1'b1;
                        ser_val  = make_header(cfg_nx, cfg_ny, 6'd0);
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            HDR: begin
                busy  = 1'b1;
                bit_d = bit_q + 4'd1;
                // Fetch word 0 early enough to be loaded at the header boundary.
                if (bit_q == HDR_PREFETCH) begin
                    mem_rd = 1'b1;
                end
                if (bit_q == HDR_LAST) begin
                    state_d  = DATA;
                    word_d   = '0;
                    ser_load = 1'b1;
                    ser_word = 1'b1;
                end
            end
            DATA: begin
                busy  = 1'b1;
                bit_d = bit_q + 4'd1;
                if (bit_q == WORD_PREFETCH && !last_word) begin
                    mem_rd = 1'b1;
                    rd_off = {1'b0, word_q} + 9'd1;
                end
                if (bit_q == WORD_LAST) begin
                    ser_load = 1'b1;
                    if (last_word) begin
                        // Zero load: the pad bit and anything after it is 0.
                        state_d = PAD;
                    end else begin
                        word_d   = word_q + 8'd1;
                        ser_word = 1'b1;
                    end
                end
            end
            PAD: begin
                busy   = 1'b1;
                base_d = base_q + ADDR_W'(w_q);
                if (row_q != rows_q) begin
                    state_d  = HDR;
                    bit_d    = '0;
                    row_d    = row_q + 6'd1;
                    ser_load = 1'b1;
                    ser_val  = make_header(nx_q, ny_q, row_q + 6'd1);
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
`ifdef I2S_SEQ_AUTOLOOP_EN
                if (loop) begin
                    busy     = 1'b1;
                    state_d  = HDR;
                    bit_d    = '0;
                    row_d    = '0;
                    base_d   = '0;
                    ser_load = 1'b1;
                    ser_val  = make_header(nx_q, ny_q, 6'd0);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    i2s_word_serializer u_ser (
        .i2s_clk   (i2s_clk),
        .rst_n     (rst_n),
        .rd        (mem_rd),
        .rdata     (mem_rdata),
        .load      (ser_load),
        .load_word (ser_word),
        .load_val  (ser_val),
        .dout      (i2s_data)
    );

endmodule

// File: tb/tb_i2s_frame_sequencer.sv
// Bench for i2s_frame_sequencer: a frame-position model (row, offset in row)
// predicts every output each cycle; directed traces pin the model to literal
// stream values, then randomized frames run with stray start pulses.
module tb_i2s_frame_sequencer;

    logic        i2s_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  cfg_nx = '0;
    logic [3:0]  cfg_ny = '0;
    logic [5:0]  cfg_rows = '0;
    logic        busy, frame_done, cfg_err, mem_rd, i2s_data;
    logic [5:0]  row_cur;
    logic [13:0] mem_addr;
    logic [15:0] mem_rdata;
`ifdef I2S_SEQ_AUTOLOOP_EN
    logic        loop = 1'b0;
`endif

    logic [15:0] mem [0:16383];
    int vectors = 0;
    int miscompares = 0;

    i2s_frame_sequencer #(.ADDR_W(14)) dut (
        .i2s_clk    (i2s_clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_nx     (cfg_nx),
        .cfg_ny     (cfg_ny),
        .cfg_rows   (cfg_rows),
`ifdef I2S_SEQ_AUTOLOOP_EN
        .loop       (loop),
`endif
        .busy       (busy),
        .frame_done (frame_done),
        .cfg_err    (cfg_err),
        .row_cur    (row_cur),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .i2s_data   (i2s_data)
    );

    always #5 i2s_clk = ~i2s_clk;

    // Frame memory: registered read, data valid the cycle after mem_rd.
    always @(posedge i2s_clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: frame position counter ----------------
    bit m_valid = 0;
    bit m_act = 0;
    bit m_err = 0;
    int m_n, m_nx, m_ny, m_rows, m_w, m_len, m_idle_row;

    initial begin
        m_idle_row = 0;
        forever begin
            @(posedge i2s_clk);
            m_err = 0;
            if (!rst_n) begin
                m_valid = 1;
                m_act = 0;
                m_idle_row = 0;
            end else if (m_act) begin
                m_n++;
                if (m_n > (m_rows + 1) * m_len) begin
                    m_act = 0;
                    m_idle_row = m_rows;
`ifdef I2S_SEQ_AUTOLOOP_EN
                    if (loop) begin
                        m_act = 1;
                        m_n = 0;
                    end
`endif
                end
            end else if (start) begin
                int w;
                w = (int'(cfg_nx) + 1) * (int'(cfg_ny) + 1);
                if (16 * w > 4095) begin
                    m_err = 1;
                end else begin
                    m_act = 1;
                    m_n = 0;
                    m_nx = int'(cfg_nx);
                    m_ny = int'(cfg_ny);
                    m_rows = int'(cfg_rows);
                    m_w = w;
                    m_len = 17 + 16 * w;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    int e_busy, e_fd, e_data, e_rd, e_addr, e_row, c_r, c_p, c_q, c_k, c_b, c_hdr;
    initial begin
        forever begin
            @(negedge i2s_clk);
            if (m_valid) begin
                e_busy = 0; e_fd = 0; e_data = 0; e_rd = 0; e_addr = 0;
                e_row = m_idle_row;
                if (m_act) begin
                    if (m_n == (m_rows + 1) * m_len) begin
                        e_fd = 1;
                        e_row = m_rows;
`ifdef I2S_SEQ_AUTOLOOP_EN
                        e_busy = int'(loop);
`endif
                    end else begin
                        c_r = m_n / m_len;
                        c_p = m_n % m_len;
                        e_row = c_r;
                        e_busy = 1;
                        if (c_p < 16) begin
                            c_hdr = m_nx * 4096 + m_ny * 256 + c_r;
                            e_data = (c_hdr >> (15 - c_p)) & 1;
                            e_rd = (c_p == 14);
                            e_addr = c_r * m_w;
                        end else if (c_p < 16 + 16 * m_w) begin
                            c_q = c_p - 16;
                            c_k = c_q / 16;
                            c_b = c_q % 16;
                            e_data = (int'(mem[c_r * m_w + c_k]) >> (15 - c_b)) & 1;
                            e_rd = (c_b == 14 && c_k < m_w - 1);
                            e_addr = c_r * m_w + c_k + 1;
                        end
                    end
                end
                chk("i2s_data", 32'(i2s_data), 32'(e_data));
                chk("busy", 32'(busy), 32'(e_busy));
                chk("frame_done", 32'(frame_done), 32'(e_fd));
                chk("cfg_err", 32'(cfg_err), 32'(m_err));
                chk("row_cur", 32'(row_cur), 32'(e_row));
                chk("mem_rd", 32'(mem_rd), 32'(e_rd));
                if (e_rd != 0) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_frame(input int nx, input int ny, input int rows);
        @(posedge i2s_clk); #2;
        cfg_nx = 4'(nx); cfg_ny = 4'(ny); cfg_rows = 6'(rows); start = 1'b1;
        @(posedge i2s_clk); #2;
        start = 1'b0;
        cfg_nx = 4'($urandom); cfg_ny = 4'($urandom); cfg_rows = 6'($urandom);
    endtask

    task automatic wait_done(input int limit, input bit perturb, output int cyc);
        cyc = 0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge i2s_clk);
            if (frame_done) begin
                start = 1'b0;
                cyc = c;
                break;
            end
            if (perturb && $urandom_range(0, 15) == 0) begin
                start = 1'b1;
                cfg_nx = 4'($urandom); cfg_ny = 4'($urandom); cfg_rows = 6'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (cyc == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_done: no frame_done within %0d cycles", limit);
        end
    endtask

    initial begin
        logic [15:0] hb0, hb1, db;
        int rd_cnt, fd_cyc, cyc, pad, nx, ny, rows;
        int rd_a [4];
        int rd_c [4];

        for (int i = 0; i < 16384; i++) mem[i] = 16'($urandom);
        mem[0] = 16'hA5C3;

        repeat (3) @(posedge i2s_clk);
        #2 rst_n = 1'b1;
        @(negedge i2s_clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_data", 32'(i2s_data), 0);
        chk("reset_row", 32'(row_cur), 0);

        // Single module, single row.
        start_frame(0, 0, 0);
        hb0 = '0; db = '0; rd_cnt = 0; fd_cyc = 0; pad = 1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge i2s_clk);
            if (c <= 16) hb0 = {hb0[14:0], i2s_data};
            else if (c <= 32) db = {db[14:0], i2s_data};
            if (c == 33) pad = int'(i2s_data);
            if (mem_rd) begin
                if (rd_cnt < 4) begin rd_a[rd_cnt] = int'(mem_addr); rd_c[rd_cnt] = c; end
                rd_cnt++;
            end
            if (frame_done && fd_cyc == 0) fd_cyc = c;
        end
        chk("t1_header", 32'(hb0), 32'h0000);
        chk("t1_payload", 32'(db), 32'hA5C3);
        chk("t1_pad", 32'(pad), 0);
        chk("t1_done_cycle", 32'(fd_cyc), 34);
        chk("t1_reads", 32'(rd_cnt), 1);
        chk("t1_read_cycle", 32'(rd_c[0]), 15);
        chk("t1_read_addr", 32'(rd_a[0]), 0);

        // Two rows, two modules across.
        start_frame(1, 0, 1);
        hb0 = '0; hb1 = '0; rd_cnt = 0; fd_cyc = 0;
        for (int c = 1; c <= 105; c++) begin
            @(negedge i2s_clk);
            if (c <= 16) hb0 = {hb0[14:0], i2s_data};
            if (c >= 50 && c <= 65) hb1 = {hb1[14:0], i2s_data};
            if (mem_rd) begin
                if (rd_cnt < 4) begin rd_a[rd_cnt] = int'(mem_addr); rd_c[rd_cnt] = c; end
                rd_cnt++;
            end
            if (frame_done && fd_cyc == 0) fd_cyc = c;
        end
        chk("t2_header0", 32'(hb0), 32'h1000);
        chk("t2_header1", 32'(hb1), 32'h1001);
        chk("t2_reads", 32'(rd_cnt), 4);
        for (int i = 0; i < 4; i++) chk("t2_read_addr", 32'(rd_a[i]), 32'(i));
        chk("t2_read_c0", 32'(rd_c[0]), 15);
        chk("t2_read_c1", 32'(rd_c[1]), 31);
        chk("t2_read_c2", 32'(rd_c[2]), 64);
        chk("t2_read_c3", 32'(rd_c[3]), 80);
        chk("t2_done_cycle", 32'(fd_cyc), 99);

        // Oversize row is rejected.
        start_frame(15, 15, 0);
        @(negedge i2s_clk);
        chk("t3_cfg_err", 32'(cfg_err), 1);
        chk("t3_busy", 32'(busy), 0);
        @(negedge i2s_clk);
        chk("t3_cfg_err_pulse", 32'(cfg_err), 0);
        repeat (20) @(negedge i2s_clk);

        // Largest legal row with a stray start mid-frame.
        start_frame(15, 14, 0);
        fd_cyc = 0;
        for (int c = 1; c <= 5000; c++) begin
            @(negedge i2s_clk);
            start = (c == 100);
            if (c == 100) begin cfg_nx = 4'd0; cfg_ny = 4'd0; end
            if (frame_done) begin fd_cyc = c; break; end
        end
        start = 1'b0;
        chk("t4_done_cycle", 32'(fd_cyc), 3858);
        repeat (3) @(negedge i2s_clk);

        // Reset during DATA of row 2, then a fresh frame.
        start_frame(1, 1, 3);
        repeat (199) @(negedge i2s_clk);
        @(negedge i2s_clk);
        chk("t5_row_before_reset", 32'(row_cur), 2);
        rst_n = 1'b0;
        @(negedge i2s_clk);
        rst_n = 1'b1;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_data", 32'(i2s_data), 0);
        chk("t5_row", 32'(row_cur), 0);
        repeat (2) @(negedge i2s_clk);
        start_frame(1, 1, 1);
        repeat (15) @(negedge i2s_clk);
        chk("t5_first_rd", 32'(mem_rd), 1);
        chk("t5_first_addr", 32'(mem_addr), 0);
        wait_done(400, 0, cyc);
        repeat (3) @(negedge i2s_clk);

        // Randomized frames with stray starts and config churn.
        for (int f = 0; f < 8; f++) begin
            nx = int'($urandom_range(0, 3));
            ny = int'($urandom_range(0, 3));
            rows = int'($urandom_range(0, 3));
            start_frame(nx, ny, rows);
            wait_done(3000, 1, cyc);
            chk("rand_frame_len", 32'(cyc), 32'((rows + 1) * (17 + 16 * (nx + 1) * (ny + 1)) + 1));
            repeat (int'($urandom_range(1, 4))) @(negedge i2s_clk);
        end

`ifdef I2S_SEQ_AUTOLOOP_EN
        // Auto-loop: frame_done every 34 cycles while loop is held.
        @(posedge i2s_clk); #2 loop = 1'b1;
        start_frame(0, 0, 0);
        rd_cnt = 0;
        for (int c = 1; c <= 110; c++) begin
            @(negedge i2s_clk);
            if (frame_done) begin
                if (rd_cnt < 4) rd_c[rd_cnt] = c;
                rd_cnt++;
            end
        end
        chk("loop_pulses", 32'(rd_cnt), 3);
        chk("loop_fd0", 32'(rd_c[0]), 34);
        chk("loop_fd1", 32'(rd_c[1]), 68);
        chk("loop_fd2", 32'(rd_c[2]), 102);
        @(posedge i2s_clk); #2 loop = 1'b0;
        wait_done(200, 0, cyc);
        repeat (3) @(negedge i2s_clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
